// File: rtl/mips_decode_alu.sv
// Single-cycle MIPS decode-and-execute: main control, ALU control, ALU, branch decision,
// plus a registered copy of the ALU result and zero flag for debug/status.
module mips_decode_alu #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instruction,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   output logic              regdst,
   output logic              alusrc,
   output logic              memtoreg,
   output logic              regwrite,
   output logic              memread,
   output logic              memwrite,
   output logic              branch_eq,
   output logic              branch_ne,
   output logic              jump,
   output logic              jal,
   output logic              jumpReg,
   output logic [1:0]        aluop,
   output logic [3:0]        ALUCon,
   output logic [DATA_W-1:0] bitOutSignExtened,
   output logic [DATA_W-1:0] outALU,
   output logic              zero,
   output logic              selBranch,
   output logic [DATA_W-1:0] result_q,
   output logic              zero_q
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_JAL   = 6'b000011,
      OP_BEQ   = 6'b000100,
      OP_BNE   = 6'b000101,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_op_e;

   localparam logic [5:0] FUNCT_JR = 6'b001000;

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [DATA_W-1:0] operand_b;
   logic              unused_fields;

   assign opcode        = instruction[31:26];
   assign funct         = instruction[5:0];
   assign imm           = instruction[15:0];
   assign unused_fields = ^instruction[25:16];

   // Main control decode.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned,
      // which would otherwise infer a latch.
      regdst    = 1'b0;
      alusrc    = 1'b0;
      memtoreg  = 1'b0;
      regwrite  = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      branch_eq = 1'b0;
      branch_ne = 1'b0;
      jump      = 1'b0;
      jal       = 1'b0;
      jumpReg   = 1'b0;
      aluop     = 2'b00;
      case (opcode)
         OP_RTYPE: begin
            regdst = 1'b1;
            aluop  = 2'b10;
            if (funct == FUNCT_JR) jumpReg  = 1'b1;
            else                   regwrite = 1'b1;
         end
         OP_LW: begin
            alusrc   = 1'b1;
            memtoreg = 1'b1;
            regwrite = 1'b1;
            memread  = 1'b1;
         end
         OP_SW: begin
            alusrc   = 1'b1;
            memwrite = 1'b1;
         end
         OP_BEQ: begin
            branch_eq = 1'b1;
            aluop     = 2'b01;
         end
         OP_BNE: begin
            branch_ne = 1'b1;
            aluop     = 2'b01;
         end
         OP_ADDI: begin
            alusrc   = 1'b1;
            regwrite = 1'b1;
         end
         OP_J: jump = 1'b1;
         OP_JAL: begin
            jump     = 1'b1;
            jal      = 1'b1;
            regwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU control; aluop 11 is reserved and behaves like add.
   always_comb begin
      ALUCon = ALU_ADD;
      case (aluop)
         2'b01: ALUCon = ALU_SUB;
         2'b10: begin
            case (funct)
               6'b100000: ALUCon = ALU_ADD;
               6'b100010: ALUCon = ALU_SUB;
               6'b100100: ALUCon = ALU_AND;
               6'b100101: ALUCon = ALU_OR;
               6'b101010: ALUCon = ALU_SLT;
               6'b100111: ALUCon = ALU_NOR;
               default:   ALUCon = ALU_ADD;
            endcase
         end
         default: ALUCon = ALU_ADD;
      endcase
   end

   assign bitOutSignExtened = {{(DATA_W-16){imm[15]}}, imm};
   assign operand_b         = alusrc ? bitOutSignExtened : data2;

   always_comb begin
      outALU = '0;
      case (ALUCon)
         ALU_AND: outALU = data1 & operand_b;
         ALU_OR:  outALU = data1 | operand_b;
         ALU_ADD: outALU = data1 + operand_b;
         ALU_SUB: outALU = data1 - operand_b;
         ALU_SLT: outALU = {{(DATA_W-1){1'b0}}, ($signed(data1) < $signed(operand_b))};
         ALU_NOR: outALU = ~(data1 | operand_b);
         default: outALU = '0;
      endcase
   end

   assign zero      = (outALU == '0);
   assign selBranch = (branch_eq & zero) | (branch_ne & ~zero);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         result_q <= outALU;
         zero_q   <= zero;
      end
   end

endmodule

// File: tb/tb_mips_decode_alu.sv
// Directed self-checking bench for mips_decode_alu: decode, ALU, branch and the
// asynchronously reset status registers, all against hand-computed values.
module tb_mips_decode_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] data1;
   logic [31:0] data2;
   logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite;
   logic        branch_eq, branch_ne, jump, jal, jumpReg;
   logic [1:0]  aluop;
   logic [3:0]  ALUCon;
   logic [31:0] bitOutSignExtened;
   logic [31:0] outALU;
   logic        zero;
   logic        selBranch;
   logic [31:0] result_q;
   logic        zero_q;
   logic [12:0] ctrl;

   int checks = 0;
   int errors = 0;

   mips_decode_alu #(.DATA_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .instruction       (instruction),
      .data1             (data1),
      .data2             (data2),
      .regdst            (regdst),
      .alusrc            (alusrc),
      .memtoreg          (memtoreg),
      .regwrite          (regwrite),
      .memread           (memread),
      .memwrite          (memwrite),
      .branch_eq         (branch_eq),
      .branch_ne         (branch_ne),
      .jump              (jump),
      .jal               (jal),
      .jumpReg           (jumpReg),
      .aluop             (aluop),
      .ALUCon            (ALUCon),
      .bitOutSignExtened (bitOutSignExtened),
      .outALU            (outALU),
      .zero              (zero),
      .selBranch         (selBranch),
      .result_q          (result_q),
      .zero_q            (zero_q)
   );

   always #5 clk = ~clk;

   // {regdst, alusrc, memtoreg, regwrite, memread, memwrite, beq, bne, jump, jal, jumpReg, aluop}
   assign ctrl = {regdst, alusrc, memtoreg, regwrite, memread, memwrite,
                  branch_eq, branch_ne, jump, jal, jumpReg, aluop};

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic apply(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      instruction = instr;
      data1       = a;
      data2       = b;
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      instruction = 32'h0;
      data1       = 32'h0;
      data2       = 32'h0;
      #2;
      check("reset result_q", result_q, 32'h0);
      check("reset zero_q", {31'h0, zero_q}, 32'h0);

      @(negedge clk);
      rst = 1'b0;

      // add $3,$1,$2
      apply(32'h0022_1820, 32'd5, 32'd7);
      check("add ctrl", {19'h0, ctrl}, {19'h0, 13'b1_0_0_1_0_0_0_0_0_0_0_10});
      check("add ALUCon", {28'h0, ALUCon}, 32'h2);
      check("add outALU", outALU, 32'd12);
      check("add zero", {31'h0, zero}, 32'h0);
      @(posedge clk);
      #1;
      check("add result_q", result_q, 32'd12);
      check("add zero_q", {31'h0, zero_q}, 32'h0);

      // lw, negative offset
      apply(32'h8C22_FFFC, 32'h0000_0100, 32'h0000_0055);
      check("lw ctrl", {19'h0, ctrl}, {19'h0, 13'b0_1_1_1_1_0_0_0_0_0_0_00});
      check("lw sext", bitOutSignExtened, 32'hFFFF_FFFC);
      check("lw outALU", outALU, 32'h0000_00FC);

      // sw
      apply(32'hAC22_0008, 32'h0000_0010, 32'h0000_0055);
      check("sw ctrl", {19'h0, ctrl}, {19'h0, 13'b0_1_0_0_0_1_0_0_0_0_0_00});
      check("sw outALU", outALU, 32'h0000_0018);

      // beq equal
      apply(32'h1022_0003, 32'd9, 32'd9);
      check("beq ctrl", {19'h0, ctrl}, {19'h0, 13'b0_0_0_0_0_0_1_0_0_0_0_01});
      check("beq ALUCon", {28'h0, ALUCon}, 32'h6);
      check("beq zero", {31'h0, zero}, 32'h1);
      check("beq selBranch", {31'h0, selBranch}, 32'h1);
      @(posedge clk);
      #1;
      check("beq zero_q", {31'h0, zero_q}, 32'h1);

      // bne equal / not equal
      apply(32'h1422_0003, 32'd9, 32'd9);
      check("bne ctrl", {19'h0, ctrl}, {19'h0, 13'b0_0_0_0_0_0_0_1_0_0_0_01});
      check("bne eq selBranch", {31'h0, selBranch}, 32'h0);
      apply(32'h1422_0003, 32'd9, 32'd8);
      check("bne ne outALU", outALU, 32'd1);
      check("bne ne selBranch", {31'h0, selBranch}, 32'h1);

      // slt signed
      apply(32'h0022_182A, 32'hFFFF_FFFF, 32'd1);
      check("slt ALUCon", {28'h0, ALUCon}, 32'h7);
      check("slt -1<1", outALU, 32'd1);
      apply(32'h0022_182A, 32'd1, 32'hFFFF_FFFF);
      check("slt 1<-1", outALU, 32'd0);
      check("slt zero", {31'h0, zero}, 32'h1);
      check("rtype no branch", {31'h0, selBranch}, 32'h0);

      // nor, sub wrap, and, or
      apply(32'h0022_1827, 32'h0, 32'h0);
      check("nor ALUCon", {28'h0, ALUCon}, 32'hC);
      check("nor outALU", outALU, 32'hFFFF_FFFF);
      apply(32'h0022_1822, 32'd3, 32'd5);
      check("sub wrap", outALU, 32'hFFFF_FFFE);
      apply(32'h0022_1824, 32'h0000_F0F0, 32'h0000_FF00);
      check("and ALUCon", {28'h0, ALUCon}, 32'h0);
      check("and outALU", outALU, 32'h0000_F000);
      apply(32'h0022_1825, 32'h0000_F0F0, 32'h0000_0F0F);
      check("or ALUCon", {28'h0, ALUCon}, 32'h1);
      check("or outALU", outALU, 32'h0000_FFFF);

      // addi with negative immediate
      apply(32'h2022_8000, 32'h0, 32'h1234_5678);
      check("addi ctrl", {19'h0, ctrl}, {19'h0, 13'b0_1_0_1_0_0_0_0_0_0_0_00});
      check("addi outALU", outALU, 32'hFFFF_8000);

      // jumps
      apply(32'h0800_0010, 32'h0, 32'h0);
      check("j ctrl", {19'h0, ctrl}, {19'h0, 13'b0_0_0_0_0_0_0_0_1_0_0_00});
      apply(32'h0C00_0010, 32'h0, 32'h0);
      check("jal ctrl", {19'h0, ctrl}, {19'h0, 13'b0_0_0_1_0_0_0_0_1_1_0_00});
      apply(32'h03E0_0008, 32'h0000_0040, 32'h0);
      check("jr ctrl", {19'h0, ctrl}, {19'h0, 13'b1_0_0_0_0_0_0_0_0_0_1_10});
      check("jr ALUCon", {28'h0, ALUCon}, 32'h2);

      // unknown opcode
      apply(32'hFC00_0000, 32'd4, 32'd4);
      check("unknown ctrl", {19'h0, ctrl}, 32'h0);
      check("unknown ALUCon", {28'h0, ALUCon}, 32'h2);
      check("unknown outALU", outALU, 32'd8);

      // async reset between edges, combinational path unaffected
      apply(32'h0022_1820, 32'd5, 32'd7);
      @(posedge clk);
      #1;
      check("pre-reset result_q", result_q, 32'd12);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async reset result_q", result_q, 32'h0);
      check("async reset zero_q", {31'h0, zero_q}, 32'h0);
      check("reset outALU live", outALU, 32'd12);
      @(posedge clk);
      #1;
      check("held reset result_q", result_q, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("released no edge", result_q, 32'h0);
      @(posedge clk);
      #1;
      check("post-reset result_q", result_q, 32'd12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
